// File: rtl/if_stage_if.sv
// Fetch-stage bus: control/redirect/training inputs, imem port and IF/ID outputs.
interface if_stage_if;
   logic        stall;
   logic        ex_redirect;
   logic [31:0] ex_redirect_pc;
   logic        id_redirect;
   logic [31:0] id_redirect_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_predict;

   // Environment side: drives control, training and imem data.
   modport master (
      output stall, ex_redirect, ex_redirect_pc, id_redirect, id_redirect_pc,
             upd_valid, upd_pc, upd_taken, inst_data,
      input  inst_addr, id_pc, id_inst, id_predict
   );

   // Fetch stage side.
   modport slave (
      input  stall, ex_redirect, ex_redirect_pc, id_redirect, id_redirect_pc,
             upd_valid, upd_pc, upd_taken, inst_data,
      output inst_addr, id_pc, id_inst, id_predict
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register and 2-bit saturating BHT.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          BHT_IDX  = 6,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.slave   bus
);
   localparam int BHT_N = 1 << BHT_IDX;

   logic [31:0]        pc_q, pc_d;
   logic [31:0]        id_pc_q, id_pc_d;
   logic [31:0]        id_inst_q, id_inst_d;
   logic               id_pred_q, id_pred_d;
   logic [1:0]         bht_q [BHT_N];
   logic [1:0]         upd_cur, upd_nxt;
   logic [BHT_IDX-1:0] rd_idx, upd_idx;
   logic               unused_upd_bits;

   assign rd_idx  = pc_q[BHT_IDX+1:2];
   assign upd_idx = bus.upd_pc[BHT_IDX+1:2];
   // Only the index bits of the training PC matter; no tags are kept.
   assign unused_upd_bits = ^{bus.upd_pc[31:BHT_IDX+2], bus.upd_pc[1:0]};

   // Outputs come straight from registers; nothing here sees stall/redirect combinationally.
   assign bus.inst_addr  = pc_q;
   assign bus.id_pc      = id_pc_q;
   assign bus.id_inst    = id_inst_q;
   assign bus.id_predict = id_pred_q;

   // Next PC and IF/ID: execute redirect beats stall, stall beats decode redirect.
   always_comb begin
      pc_d      = pc_q;
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
      id_pred_d = id_pred_q;
      if (bus.ex_redirect) begin
         pc_d      = bus.ex_redirect_pc;
         id_pc_d   = 32'h0;
         id_inst_d = NOP_INST;
         id_pred_d = 1'b0;
      end else if (!bus.stall) begin
         if (bus.id_redirect) begin
            // The instruction fetched this cycle is wrong-path; replace with a bubble.
            pc_d      = bus.id_redirect_pc;
            id_pc_d   = 32'h0;
            id_inst_d = NOP_INST;
            id_pred_d = 1'b0;
         end else begin
            pc_d      = pc_q + 32'd4;
            id_pc_d   = pc_q;
            id_inst_d = bus.inst_data;
            id_pred_d = bht_q[rd_idx][1];
         end
      end
   end

   // PC and IF/ID register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         id_pc_q   <= 32'h0;
         id_inst_q <= NOP_INST;
         id_pred_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         id_pc_q   <= id_pc_d;
         id_inst_q <= id_inst_d;
         id_pred_q <= id_pred_d;
      end
   end

   // Saturating counter step for the entry being trained.
   always_comb begin
      upd_cur = bht_q[upd_idx];
      upd_nxt = upd_cur;
      if (bus.upd_taken && upd_cur != 2'b11)
         upd_nxt = upd_cur + 2'd1;
      else if (!bus.upd_taken && upd_cur != 2'b00)
         upd_nxt = upd_cur - 2'd1;
   end

   // BHT training ignores stall/redirect; reads in the same cycle see the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_N; i++)
            bht_q[i] <= 2'b01;
      end else if (bus.upd_valid) begin
         bht_q[upd_idx] <= upd_nxt;
      end
   end
endmodule
